branch_predict_unit: RTL and testbench

//  Parametrised successor to the flag-based branch resolver. Resolves conditional branches in EX

---
 rtl/branch_predict_unit_pkg.sv | 37 +++
 rtl/branch_predict_unit_sat_counter2.sv | 24 ++
 rtl/branch_predict_unit.sv | 77 +++++++
 tb/tb_branch_predict_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Branch func3 encodings, BHT counter states and the flag-based branch condition helpers.
package branch_predict_unit_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    function automatic logic br_legal(input logic [2:0] func3);
        return (func3 != 3'b010) && (func3 != 3'b011);
    endfunction

    // Flags come from rs1 - rs2: signed less-than is s^v, unsigned less-than is a borrow (~c).
    function automatic logic br_eval(input logic [2:0] func3, input logic s, input logic z,
                                     input logic c, input logic v);
        logic t;
        t = 1'b0;
        case (func3)
            BR_BEQ:  t = z;
            BR_BNE:  t = ~z;
            BR_BLT:  t = s ^ v;
            BR_BGE:  t = ~(s ^ v);
            BR_BLTU: t = ~c;
            BR_BGEU: t = c;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// One BHT entry: 2-bit saturating counter, increment has priority if both enables are set.
module branch_predict_unit_sat_counter2
    import branch_predict_unit_pkg::*;
#(
    parameter logic [1:0] INIT_STATE = BHT_WNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT_STATE;
        end else if (inc) begin
            if (state != BHT_ST) state <= state + 2'd1;
        end else if (dec) begin
            if (state != BHT_SNT) state <= state - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Resolves conditional branches from ALU flags in EX and predicts them in IF from a 2-bit BHT;
// flags mispredicts and keeps saturating branch/mispredict statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         IDX_BITS   = 6,
    parameter int         CNT_W      = 16,
    parameter logic [1:0] INIT_STATE = BHT_WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [31:0]      ex_pc,
    input  logic [2:0]       ex_func3,
    input  logic             ex_pred_taken,
    input  logic             s,
    input  logic             z,
    input  logic             c,
    input  logic             v,
    output logic             ex_taken,
    output logic             mispredict,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic [1:0]          bht [DEPTH];
    logic                resolve;
    logic                cond_true;
    logic                unused_pc_bits;

    // Halfword-granular index keeps compressed branches in distinct entries.
    assign rd_idx = if_pc[IDX_BITS:1];
    assign wr_idx = ex_pc[IDX_BITS:1];
    assign unused_pc_bits = ^{if_pc[31:IDX_BITS+1], if_pc[0], ex_pc[31:IDX_BITS+1], ex_pc[0]};

    // ex_valid gates everything first so X on the other EX inputs cannot reach state.
    assign resolve    = ex_valid & ex_branch & br_legal(ex_func3);
    assign cond_true  = br_eval(ex_func3, s, z, c, v);
    assign ex_taken   = resolve & cond_true;
    assign mispredict = resolve & (cond_true ^ ex_pred_taken);
    assign illegal_br = ex_valid & ex_branch & ~br_legal(ex_func3);

    assign if_pred_taken = bht[rd_idx][1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_bht
        logic hit;
        assign hit = resolve && (wr_idx == IDX_BITS'(i));
        branch_predict_unit_sat_counter2 #(
            .INIT_STATE(INIT_STATE)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (hit & cond_true),
            .dec  (hit & ~cond_true),
            .state(bht[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (resolve && (br_count != '1)) br_count <= br_count + 1'b1;
            if (mispredict && (mispred_count != '1)) mispred_count <= mispred_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with 4-bit statistics counters so saturation is reachable.
module tb_branch_predict_unit;
    localparam int IDX_BITS = 6;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic             ex_valid, ex_branch, ex_pred_taken;
    logic [31:0]      ex_pc;
    logic [2:0]       ex_func3;
    logic             s, z, c, v;
    logic             ex_taken, mispredict, illegal_br;
    logic [CNT_W-1:0] br_count, mispred_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_br = 0;
    int exp_mp = 0;

    branch_predict_unit #(
        .IDX_BITS(IDX_BITS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_pc        (if_pc),
        .if_pred_taken(if_pred_taken),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_pc        (ex_pc),
        .ex_func3     (ex_func3),
        .ex_pred_taken(ex_pred_taken),
        .s            (s),
        .z            (z),
        .c            (c),
        .v            (v),
        .ex_taken     (ex_taken),
        .mispredict   (mispredict),
        .illegal_br   (illegal_br),
        .br_count     (br_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".br_count"}, 32'(br_count), 32'(exp_br));
        chk({tag, ".mispred_count"}, 32'(mispred_count), 32'(exp_mp));
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic [3:0] szcv);
        logic fs, fz, fc, fv;
        {fs, fz, fc, fv} = szcv;
        case (f3)
            3'b000:  return fz;
            3'b001:  return !fz;
            3'b100:  return fs != fv;
            3'b101:  return fs == fv;
            3'b110:  return !fc;
            3'b111:  return fc;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_ex();
        ex_valid = 1'b0;
        ex_branch = 1'bx;
        ex_pc = 'x;
        ex_func3 = 'x;
        ex_pred_taken = 1'bx;
        {s, z, c, v} = 4'bxxxx;
    endtask

    // Called just after a rising edge; checks EX outputs and the IF prediction mid-cycle, then clocks.
    task automatic res(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                       input logic pred, input logic [3:0] szcv, input logic exp_t,
                       input logic exp_if);
        ex_valid = 1'b1;
        ex_branch = 1'b1;
        ex_pc = pc;
        ex_func3 = f3;
        ex_pred_taken = pred;
        {s, z, c, v} = szcv;
        #2;
        chk({tag, ".ex_taken"}, 32'(ex_taken), 32'(exp_t));
        chk({tag, ".mispredict"}, 32'(mispredict), 32'(exp_t ^ pred));
        chk({tag, ".illegal_br"}, 32'(illegal_br), 32'd0);
        chk({tag, ".if_pred"}, 32'(if_pred_taken), 32'(exp_if));
        if (exp_br < CNT_MAX) exp_br++;
        if ((exp_t ^ pred) && exp_mp < CNT_MAX) exp_mp++;
        @(posedge clk);
        #1;
        idle_ex();
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h100;
        idle_ex();
        #3;
        chk("rst.if_pred", 32'(if_pred_taken), 32'd0);
        chk_cnt("rst");
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        // Two taken BEQs on a weakly-not-taken entry, then walk it back down from strong-taken.
        res("beq1", 32'h100, 3'b000, 1'b0, 4'b0100, 1'b1, 1'b0);
        res("beq2", 32'h100, 3'b000, 1'b0, 4'b0100, 1'b1, 1'b1);
        chk("beq.after2", 32'(if_pred_taken), 32'd1);
        chk_cnt("beq.after2");
        res("beq3", 32'h100, 3'b000, 1'b1, 4'b0000, 1'b0, 1'b1);
        chk("beq.after3", 32'(if_pred_taken), 32'd1);
        res("beq4", 32'h100, 3'b000, 1'b1, 4'b0000, 1'b0, 1'b1);
        chk("beq.after4", 32'(if_pred_taken), 32'd0);
        chk_cnt("beq.after4");

        // X on EX inputs while not valid must leave everything alone.
        repeat (3) @(posedge clk);
        #1;
        chk("xidle.ex_taken", 32'(ex_taken), 32'd0);
        chk("xidle.mispredict", 32'(mispredict), 32'd0);
        chk("xidle.illegal", 32'(illegal_br), 32'd0);
        chk("xidle.if_pred", 32'(if_pred_taken), 32'd0);
        chk_cnt("xidle");

        for (int k = 0; k < 2; k++) begin
            ex_valid = 1'b1;
            ex_branch = 1'b1;
            ex_pc = 32'h100;
            ex_func3 = (k == 0) ? 3'b010 : 3'b011;
            ex_pred_taken = 1'b1;
            {s, z, c, v} = 4'b0110;
            #2;
            chk("illegal.flag", 32'(illegal_br), 32'd1);
            chk("illegal.ex_taken", 32'(ex_taken), 32'd0);
            chk("illegal.mispredict", 32'(mispredict), 32'd0);
            @(posedge clk);
            #1;
            idle_ex();
            chk("illegal.if_pred", 32'(if_pred_taken), 32'd0);
            chk_cnt("illegal");
        end

        // 0x180 aliases 0x100 (index 0); 0x102 is index 1.
        res("alias", 32'h180, 3'b001, 1'b0, 4'b0000, 1'b1, 1'b0);
        chk("alias.0x100", 32'(if_pred_taken), 32'd1);
        if_pc = 32'h102;
        #1;
        chk("alias.0x102", 32'(if_pred_taken), 32'd0);
        chk_cnt("alias");

        // Predict and update index 1 in the same cycle: old value now, new value after the edge.
        res("same.up", 32'h102, 3'b111, 1'b0, 4'b0010, 1'b1, 1'b0);
        chk("same.up.next", 32'(if_pred_taken), 32'd1);
        res("same.dn", 32'h102, 3'b001, 1'b0, 4'b0100, 1'b0, 1'b1);
        chk("same.dn.next", 32'(if_pred_taken), 32'd0);
        chk_cnt("same");

        // Full func3 x flag sweep on index 0x20; index 0 (0x100) stays weakly taken throughout.
        if_pc = 32'h100;
        begin
            logic [2:0] f3s [6];
            logic [2:0] f3;
            f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
            for (int fi = 0; fi < 6; fi++) begin
                for (int fl = 0; fl < 16; fl++) begin
                    f3 = f3s[fi];
                    res($sformatf("sweep.f%0d.%0h", f3, fl), 32'h040, f3, 1'b0, 4'(fl),
                        ref_taken(f3, 4'(fl)), 1'b1);
                end
            end
        end
        chk_cnt("sweep");
        chk("sweep.br_sat", 32'(br_count), 32'hF);

        for (int k = 0; k < 20; k++)
            res("mpsat", 32'h040, 3'b000, 1'b1, 4'b0000, 1'b0, 1'b1);
        chk("mpsat.hold", 32'(mispred_count), 32'hF);
        chk_cnt("mpsat");

        // Async reset in mid-cycle with a resolve pending; first edge afterwards updates normally.
        ex_valid = 1'b1;
        ex_branch = 1'b1;
        ex_pc = 32'h100;
        ex_func3 = 3'b000;
        ex_pred_taken = 1'b0;
        {s, z, c, v} = 4'b0100;
        #2 rst = 1'b1;
        #1;
        exp_br = 0;
        exp_mp = 0;
        chk_cnt("arst");
        chk("arst.if_pred", 32'(if_pred_taken), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        idle_ex();
        exp_br = 1;
        exp_mp = 1;
        chk_cnt("arst.after");
        chk("arst.after.if_pred", 32'(if_pred_taken), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
